mips_fetch_unit: RTL and testbench
==================================

# mips_fetch_unit

- Pipelined instruction fetch stage directly upstream of the MIPS decode/execute core.
- Keeps its own fetch PC and issues word reads to instruction memory over a valid/ready request channel with in-order, variable-latency responses.
- Buffers returned words with their PCs in a small prefetch FIFO and presents them to decode over a valid/ready handshake.
- A redirect from execute (branch taken / jump) flushes the FIFO and discards stale in-flight responses.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, first fetch address after reset; bits [1:0] must be 0
- DEPTH, 4, prefetch FIFO entries; power of two, ≥2; also the cap on buffered plus live in-flight requests

Ports:
- clk  in  1  clock; everything is sampled on the rising edge
- rst  in  1  reset, synchronous, active-low (reset when rst==0 at posedge clk)
- imem_req_valid  out  1  fetch request valid
- imem_req_ready  in  1  memory accepts request
- imem_req_addr  out  32  word-aligned fetch address
- imem_resp_valid  in  1  response word valid; responses arrive in request order, one per accepted request, with no backpressure
- imem_resp_data  in  32  instruction word
- redirect_valid  in  1  flush and restart fetch
- redirect_target  in  32  new fetch PC; bits [1:0] forced to 0
- if_valid  out  1  instruction available to decode
- if_ready  in  1  decode accepts
- if_instr  out  32  instruction word
- if_pc  out  32  PC of if_instr

## Operation
State registers:
- fetch_pc: next address to request
- resp_pc: PC of the next live response
- live_cnt: in-flight requests whose responses will be kept
- drop_cnt: in-flight requests whose responses will be discarded
- FIFO of {pc, instr}, with count fifo_cnt

Counters are $clog2(DEPTH+1) bits wide. PC arithmetic is 32-bit modulo; 32'hFFFF_FFFC + 4 wraps to 0.

Request issue:
- imem_req_valid = !redirect_valid && (fifo_cnt + live_cnt < DEPTH).
- imem_req_addr = fetch_pc.
- On handshake: fetch_pc += 4, live_cnt += 1.

Response, no redirect in that cycle:
- If drop_cnt > 0: discard the word, drop_cnt -= 1.
- Otherwise: push {resp_pc, imem_resp_data}, resp_pc += 4, live_cnt -= 1.
- The credit rule guarantees a push never hits a full FIFO. If one does, it is an assertion failure.

Output:
- if_valid = (fifo_cnt != 0) && !redirect_valid; if_instr and if_pc come from the FIFO head.
- Pop on if_valid && if_ready.
- A push and a pop in the same cycle leave fifo_cnt unchanged.

Redirect cycle (takes priority over everything else):
- FIFO flushed; fifo_cnt becomes 0.
- No request issued; no pop.
- fetch_pc ← resp_pc ← {redirect_target[31:2], 2'b00}.
- drop_cnt ← live_cnt + drop_cnt − imem_resp_valid; any response arriving in this cycle is discarded.
- live_cnt ← 0.

Back-to-back redirects: the last one wins, and drop accounting accumulates across them.

Reset (rst==0):
- fetch_pc = resp_pc = RESET_PC; all counters 0; FIFO empty.
- Outputs: imem_req_valid=0, if_valid=0, imem_req_addr=RESET_PC, if_instr=0, if_pc=0.
- Reset mid-operation drops all state. Responses to pre-reset requests are the memory's responsibility: memory is reset in the same cycle.

## Timing
- First request: imem_req_valid=1 with addr RESET_PC in the first cycle after rst rises.
- Response to decode: a response pushed at edge N gives if_valid=1 in cycle N+1. Latency is 1 cycle, registered FIFO; there is no combinational path from imem_resp_* to if_*.
- Throughput: sustained 1 instr/cycle requires DEPTH ≥ memory latency + 1.
- Redirect: redirect_valid in cycle N → if_valid=0 and imem_req_valid=0 in cycle N. The request to the target issues in cycle N+1.
- Combinational paths: if_valid and imem_req_valid depend combinationally on redirect_valid only. All other outputs are register-driven.

## Structure
- Shared package mips_pkg: t_opcode, t_alu_ctrl, and the constant INSTR_BYTES=4. The package is shared with the core.
- Sub-module mips_sync_fifo: parameterized WIDTH/DEPTH, synchronous flush, push/pop, count output, active-low synchronous reset. Instantiated with WIDTH=64.
- The counters and the two PC registers live in mips_fetch_unit.

## Test plan
- Reset/fill:
  - Stimulus: rst low 3 cycles; memory with latency 1, always ready; if_ready=1.
  - Required: requests for 0x0, 0x4, 0x8…; if_pc sequence 0x0, 0x4, 0x8 with instr = mem[pc]; one per cycle once streaming.
- Backpressure:
  - Stimulus: if_ready=0 for 10 cycles.
  - Required: fifo_cnt + live_cnt never exceeds 4; imem_req_valid drops to 0; no instruction lost or duplicated after if_ready=1.
- Redirect with in-flight responses:
  - Stimulus: memory latency 3; redirect to 0x100 while 2 requests are outstanding.
  - Required: both stale responses discarded; next if_pc=0x100, then 0x104.
- Redirect coincident with response and pop:
  - Stimulus: redirect_valid, imem_resp_valid and if_ready all high in the same cycle; target 0x203.
  - Required: that response dropped; fetch resumes at 0x200; if_valid=0 in that cycle.
- Memory stall and wrap-around:
  - Stimulus: imem_req_ready toggling randomly; RESET_PC=32'hFFFF_FFF8.
  - Required: if_pc sequence FFFF_FFF8, FFFF_FFFC, 0000_0000, in order, with no gaps.
- Mid-run reset:
  - Stimulus: rst=0 while the FIFO is full.
  - Required: next cycle if_valid=0, imem_req_valid=0; after release, fetch restarts at RESET_PC.

Source files
------------

// File: rtl/mips_pkg.sv
// Types and constants shared between the fetch stage and the MIPS core.
package mips_pkg;

  localparam int unsigned INSTR_BYTES = 4;

  typedef enum logic [5:0] {
    OP_RTYPE  = 6'h00,
    OP_REGIMM = 6'h01,
    OP_J      = 6'h02,
    OP_JAL    = 6'h03,
    OP_BEQ    = 6'h04,
    OP_BNE    = 6'h05,
    OP_ADDI   = 6'h08,
    OP_ADDIU  = 6'h09,
    OP_SLTI   = 6'h0A,
    OP_ANDI   = 6'h0C,
    OP_ORI    = 6'h0D,
    OP_XORI   = 6'h0E,
    OP_LUI    = 6'h0F,
    OP_LW     = 6'h23,
    OP_SW     = 6'h2B
  } t_opcode;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_NOR,
    ALU_SLT, ALU_SLTU, ALU_SLL, ALU_SRL, ALU_SRA, ALU_LUI
  } t_alu_ctrl;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } t_fetch_entry;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/mips_sync_fifo.sv
// Synchronous FIFO with registered storage, flush and occupancy count.
module mips_sync_fifo #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush,
  input  logic                         push,
  input  logic [WIDTH-1:0]             push_data,
  input  logic                         pop,
  output logic [WIDTH-1:0]             head,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH+1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;

  assign head = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (!rst) begin
      mem    <= '{default: '0};
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      // Upstream credit accounting must never let a push reach a full FIFO.
      assert (!(push && count == FULL));
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
    end
  end

endmodule

// File: rtl/mips_fetch_unit.sv
// Instruction fetch stage: PC generation, credit-limited memory requests,
// prefetch buffering and redirect handling with stale-response dropping.
module mips_fetch_unit
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned DEPTH    = 4
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  output logic        if_valid,
  input  logic        if_ready,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc
);

  localparam int unsigned CW   = $clog2(DEPTH+1);
  localparam logic [CW:0] CAP  = (CW+1)'(DEPTH);
  localparam logic [31:0] STEP = 32'(INSTR_BYTES);

  logic [31:0]   fetch_pc;
  logic [31:0]   resp_pc;
  logic [CW-1:0] live_cnt;
  logic [CW-1:0] drop_cnt;
  logic [CW-1:0] fifo_cnt;
  logic          active;
  logic          has_credit;
  logic          req_fire;
  logic          push;
  logic          resp_drop;
  logic          pop;
  t_fetch_entry  push_entry;
  t_fetch_entry  head;

  // active holds request issue off for the whole reset period without a
  // combinational path from rst to the outputs.
  assign has_credit     = ({1'b0, fifo_cnt} + {1'b0, live_cnt}) < CAP;
  assign imem_req_valid = active && !redirect_valid && has_credit;
  assign imem_req_addr  = fetch_pc;
  assign req_fire       = imem_req_valid && imem_req_ready;

  assign resp_drop = imem_resp_valid && !redirect_valid && (drop_cnt != '0);
  assign push      = imem_resp_valid && !redirect_valid && (drop_cnt == '0);
  assign push_entry = '{pc: resp_pc, instr: imem_resp_data};

  assign if_valid = !redirect_valid && (fifo_cnt != '0);
  assign pop      = if_valid && if_ready;
  assign if_pc    = head.pc;
  assign if_instr = head.instr;

  mips_sync_fifo #(
    .WIDTH (64),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .flush     (redirect_valid),
    .push      (push),
    .push_data (push_entry),
    .pop       (pop),
    .head      (head),
    .count     (fifo_cnt)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      fetch_pc <= RESET_PC;
      resp_pc  <= RESET_PC;
      live_cnt <= '0;
      drop_cnt <= '0;
      active   <= 1'b0;
    end else begin
      active <= 1'b1;
      if (redirect_valid) begin
        // Everything still in flight becomes stale; a response arriving now
        // is discarded directly instead of being counted.
        fetch_pc <= word_align(redirect_target);
        resp_pc  <= word_align(redirect_target);
        drop_cnt <= live_cnt + drop_cnt - CW'(imem_resp_valid);
        live_cnt <= '0;
      end else begin
        if (req_fire)  fetch_pc <= fetch_pc + STEP;
        if (push)      resp_pc  <= resp_pc + STEP;
        if (resp_drop) drop_cnt <= drop_cnt - 1'b1;
        live_cnt <= live_cnt + CW'(req_fire) - CW'(push);
      end
    end
  end

endmodule

// File: tb/tb_mips_fetch_unit.sv
// Randomized bench for mips_fetch_unit against an in-order memory model and
// an expected-PC-stream scoreboard.
module tb_mips_fetch_unit;

  localparam logic [31:0] RPC   = 32'hFFFF_FFF8;
  localparam int          DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_instr;
  logic [31:0] if_pc;

  always #5 clk = ~clk;

  mips_fetch_unit #(
    .RESET_PC (RPC),
    .DEPTH    (DEPTH)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .imem_req_valid  (imem_req_valid),
    .imem_req_ready  (imem_req_ready),
    .imem_req_addr   (imem_req_addr),
    .imem_resp_valid (imem_resp_valid),
    .imem_resp_data  (imem_resp_data),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .if_valid        (if_valid),
    .if_ready        (if_ready),
    .if_instr        (if_instr),
    .if_pc           (if_pc)
  );

  typedef struct {
    int unsigned due;
    logic [31:0] addr;
  } req_t;

  req_t        pend[$];
  logic [31:0] seen[$];
  int unsigned cyc = 0;
  int unsigned lat_min = 1;
  int unsigned lat_max = 1;
  logic [31:0] exp_pc  = RPC;
  logic [31:0] exp_req = RPC;
  int          owed = 0;
  int          n_cmp = 0;
  int          n_err = 0;

  function automatic logic [31:0] memf(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  task automatic settle();
    imem_resp_valid = rst && (pend.size() > 0) && (pend[0].due <= cyc);
    imem_resp_data  = imem_resp_valid ? memf(pend[0].addr) : $urandom;
    #1;
  endtask

  task automatic advance();
    logic fire, popv, rv, rd, r;
    logic [31:0] a, tgt;
    int unsigned lat;
    fire = imem_req_valid && imem_req_ready;
    popv = if_valid && if_ready;
    rv   = imem_resp_valid;
    rd   = redirect_valid;
    r    = rst;
    a    = imem_req_addr;
    tgt  = redirect_target;
    @(posedge clk);
    #1;
    cyc++;
    if (!r) begin
      pend.delete();
      exp_pc  = RPC;
      exp_req = RPC;
      owed    = 0;
    end else begin
      if (rv) void'(pend.pop_front());
      if (fire) begin
        lat = $urandom_range(lat_max, lat_min);
        pend.push_back('{due: cyc - 1 + lat, addr: a});
      end
      if (rd) begin
        exp_pc  = {tgt[31:2], 2'b00};
        exp_req = {tgt[31:2], 2'b00};
        owed    = 0;
      end else begin
        if (fire) begin exp_req += 32'd4; owed++; end
        if (popv) begin exp_pc  += 32'd4; owed--; end
      end
    end
  endtask

  task automatic test_stream(input int n, input int rdy_pct, input int ifr_pct);
    repeat (n) begin
      redirect_valid = 1'b0;
      imem_req_ready = ($urandom_range(99) < rdy_pct);
      if_ready       = ($urandom_range(99) < ifr_pct);
      settle();
      n_cmp++;
      if (imem_req_valid !== (owed < DEPTH)) begin
        n_err++;
        $display("FAIL credit: req_valid=%b required %b (buffered+in-flight=%0d)",
                 imem_req_valid, owed < DEPTH, owed);
      end
      if (imem_req_valid && imem_req_ready) begin
        n_cmp++;
        if (imem_req_addr !== exp_req) begin
          n_err++;
          $display("FAIL req_addr: got %h required %h", imem_req_addr, exp_req);
        end
      end
      if (if_valid && if_ready) begin
        n_cmp++;
        if (if_pc !== exp_pc || if_instr !== memf(exp_pc)) begin
          n_err++;
          $display("FAIL pop: pc=%h instr=%h required pc=%h instr=%h",
                   if_pc, if_instr, exp_pc, memf(exp_pc));
        end
        seen.push_back(if_pc);
      end
      advance();
    end
  endtask

  task automatic do_reset(input int n);
    rst = 1'b0;
    redirect_valid = 1'b0;
    repeat (n) begin settle(); advance(); end
    rst = 1'b1;
    settle();
    advance();
    settle();
  endtask

  task automatic test_reset();
    rst = 1'b0; if_ready = 1'b1; imem_req_ready = 1'b1;
    redirect_valid = 1'b0; redirect_target = '0;
    lat_min = 1; lat_max = 1;
    settle();
    advance();
    repeat (2) begin
      settle();
      n_cmp++;
      if (imem_req_valid !== 1'b0 || if_valid !== 1'b0 || imem_req_addr !== RPC ||
          if_instr !== '0 || if_pc !== '0) begin
        n_err++;
        $display("FAIL reset_outputs: req_valid=%b if_valid=%b addr=%h instr=%h pc=%h required 0 0 %h 0 0",
                 imem_req_valid, if_valid, imem_req_addr, if_instr, if_pc, RPC);
      end
      advance();
    end
    rst = 1'b1;
    settle();
    advance();
    settle();
    n_cmp++;
    if (imem_req_valid !== 1'b1 || imem_req_addr !== RPC) begin
      n_err++;
      $display("FAIL first_req: valid=%b addr=%h required 1 %h", imem_req_valid, imem_req_addr, RPC);
    end
  endtask

  task automatic test_fill();
    seen.delete();
    test_stream(12, 100, 100);
    n_cmp++;
    if (seen.size() != 10) begin
      n_err++;
      $display("FAIL fill_latency: pops=%0d required 10", seen.size());
    end
    test_stream(10, 100, 100);
    n_cmp++;
    if (seen.size() != 20) begin
      n_err++;
      $display("FAIL fill_rate: pops=%0d required 20", seen.size());
    end
  endtask

  task automatic test_backpressure();
    test_stream(10, 100, 0);
    settle();
    n_cmp++;
    if (imem_req_valid !== 1'b0) begin
      n_err++;
      $display("FAIL bp_stall: req_valid=%b required 0", imem_req_valid);
    end
    seen.delete();
    test_stream(20, 100, 100);
    n_cmp++;
    if (seen.size() < 15) begin
      n_err++;
      $display("FAIL bp_resume: pops=%0d required >=15", seen.size());
    end
  endtask

  task automatic test_redirect_inflight();
    lat_min = 3; lat_max = 3;
    test_stream(8, 0, 100);
    test_stream(2, 100, 100);
    redirect_valid = 1'b1; redirect_target = 32'h0000_0100;
    imem_req_ready = 1'b1; if_ready = 1'b1;
    settle();
    n_cmp++;
    if (pend.size() != 2 || if_valid !== 1'b0 || imem_req_valid !== 1'b0) begin
      n_err++;
      $display("FAIL redir_cycle: outstanding=%0d if_valid=%b req_valid=%b required 2 0 0",
               pend.size(), if_valid, imem_req_valid);
    end
    advance();
    seen.delete();
    test_stream(15, 100, 100);
    n_cmp++;
    if (seen.size() < 2 || seen[0] !== 32'h100 || seen[1] !== 32'h104) begin
      n_err++;
      $display("FAIL redir_target: pops=%0d first=%h second=%h required 100 104",
               seen.size(), seen.size() > 0 ? seen[0] : 32'hx, seen.size() > 1 ? seen[1] : 32'hx);
    end
  endtask

  task automatic test_redirect_coincident();
    lat_min = 1; lat_max = 1;
    test_stream(6, 100, 100);
    redirect_valid = 1'b1; redirect_target = 32'h0000_0203;
    imem_req_ready = 1'b1; if_ready = 1'b1;
    settle();
    n_cmp++;
    if (imem_resp_valid !== 1'b1 || if_valid !== 1'b0 || imem_req_valid !== 1'b0) begin
      n_err++;
      $display("FAIL coinc_cycle: resp_valid=%b if_valid=%b req_valid=%b required 1 0 0",
               imem_resp_valid, if_valid, imem_req_valid);
    end
    advance();
    redirect_valid = 1'b0;
    settle();
    n_cmp++;
    if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h200) begin
      n_err++;
      $display("FAIL coinc_req: valid=%b addr=%h required 1 00000200", imem_req_valid, imem_req_addr);
    end
    seen.delete();
    test_stream(10, 100, 100);
    n_cmp++;
    if (seen.size() < 1 || seen[0] !== 32'h200) begin
      n_err++;
      $display("FAIL coinc_target: pops=%0d first=%h required 00000200",
               seen.size(), seen.size() > 0 ? seen[0] : 32'hx);
    end
  endtask

  task automatic test_stall_wrap();
    do_reset(2);
    lat_min = 1; lat_max = 3;
    seen.delete();
    test_stream(80, 50, 70);
    n_cmp++;
    if (seen.size() < 3 || seen[0] !== 32'hFFFF_FFF8 || seen[1] !== 32'hFFFF_FFFC ||
        seen[2] !== 32'h0000_0000) begin
      n_err++;
      $display("FAIL wrap: pops=%0d first three=%h %h %h required fffffff8 fffffffc 00000000",
               seen.size(), seen.size() > 0 ? seen[0] : 32'hx,
               seen.size() > 1 ? seen[1] : 32'hx, seen.size() > 2 ? seen[2] : 32'hx);
    end
  endtask

  task automatic test_mid_reset();
    lat_min = 1; lat_max = 1;
    test_stream(10, 100, 0);
    settle();
    n_cmp++;
    if (owed != DEPTH || if_valid !== 1'b1) begin
      n_err++;
      $display("FAIL full_before_reset: buffered=%0d if_valid=%b required %0d 1", owed, if_valid, DEPTH);
    end
    rst = 1'b0;
    settle();
    advance();
    rst = 1'b1;
    settle();
    n_cmp++;
    if (if_valid !== 1'b0 || imem_req_valid !== 1'b0) begin
      n_err++;
      $display("FAIL midreset_outputs: if_valid=%b req_valid=%b required 0 0", if_valid, imem_req_valid);
    end
    advance();
    settle();
    n_cmp++;
    if (imem_req_valid !== 1'b1 || imem_req_addr !== RPC) begin
      n_err++;
      $display("FAIL midreset_restart: valid=%b addr=%h required 1 %h", imem_req_valid, imem_req_addr, RPC);
    end
    seen.delete();
    test_stream(10, 100, 100);
    n_cmp++;
    if (seen.size() < 1 || seen[0] !== RPC) begin
      n_err++;
      $display("FAIL midreset_first: pops=%0d first=%h required %h",
               seen.size(), seen.size() > 0 ? seen[0] : 32'hx, RPC);
    end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_backpressure();
    test_redirect_inflight();
    test_redirect_coincident();
    test_stall_wrap();
    test_mid_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1);
  end

endmodule
